// File: rtl/acc_pkg.sv
// Shared types for the nibble-serial accumulator ALU sequencer:
// FSM state encoding and external-ALU mode constants.
package acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;

endpackage

// File: rtl/acc_alu_seq.sv
// Drives a 4-bit external ALU one nibble per cycle, LSB first, chaining carry.
// Ports: clk/rst_n, start, op_s/op_m/cin_n, opa/opb in; busy, done, result,
// cout_n out; alu_* drive to ALU, alu_y/alu_cout_n return.
// Optional: SEQ_ZFLAG_EN adds output zero (result all zeros, held with result).
module acc_alu_seq
  import acc_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           op_s,
  input  logic                 op_m,
  input  logic                 cin_n,
  input  logic [4*NIBBLES-1:0] opa,
  input  logic [4*NIBBLES-1:0] opb,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout_n,
`ifdef SEQ_ZFLAG_EN
  output logic                 zero,
`endif
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cin_n,
  input  logic [3:0]           alu_y,
  input  logic                 alu_cout_n
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  state_t        state, state_n;
  logic [KW-1:0] k;
  logic [W-1:0]  a_q, b_q;
  logic [3:0]    s_q;
  logic          m_q;
  logic          cin_q;
  logic          carry_q;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_nx;
  logic          accept;

  assign accept = start && (state != ST_RUN);
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        state_n = start ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (k == K_LAST) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Slices build up in acc so the previous result stays visible
  // until the final slice lands.
  always_comb begin
    acc_nx = acc;
    acc_nx[4*k +: 4] = alu_y;
  end

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_s     = '0;
    alu_m     = 1'b0;
    alu_cin_n = 1'b1;
    if (state == ST_RUN) begin
      alu_a     = a_q[4*k +: 4];
      alu_b     = b_q[4*k +: 4];
      alu_s     = s_q;
      alu_m     = m_q;
      alu_cin_n = (k == '0) ? cin_q : carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b1;
      carry_q <= 1'b1;
      acc     <= '0;
      result  <= '0;
      cout_n  <= 1'b1;
`ifdef SEQ_ZFLAG_EN
      zero    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        a_q   <= opa;
        b_q   <= opb;
        s_q   <= op_s;
        m_q   <= op_m;
        cin_q <= cin_n;
        k     <= '0;
      end else if (state == ST_RUN) begin
        acc     <= acc_nx;
        carry_q <= alu_cout_n;
        k       <= k + 1'b1;
        if (k == K_LAST) begin
          result <= acc_nx;
          cout_n <= alu_cout_n;
`ifdef SEQ_ZFLAG_EN
          zero   <= ~|acc_nx;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_alu_seq.sv
// Bench for acc_alu_seq: 4-bit ALU model, full-width reference model,
// per-cycle compare process and directed vectors.
module tb_acc_alu_seq;
  import acc_pkg::*;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op_s = '0;
  logic         op_m = 1'b0;
  logic         cin_n = 1'b1;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy, done, cout_n;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_s, alu_y;
  logic         alu_m, alu_cin_n, alu_cout_n;
`ifdef SEQ_ZFLAG_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;

  acc_alu_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_s(op_s), .op_m(op_m), .cin_n(cin_n),
    .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .cout_n(cout_n),
`ifdef SEQ_ZFLAG_EN
    .zero(zero),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
    .alu_cin_n(alu_cin_n), .alu_y(alu_y), .alu_cout_n(alu_cout_n)
  );

  always #5 clk = ~clk;

  // External 4-bit ALU (subset of 74181-style functions)
  always_comb begin
    logic [4:0] sum;
    logic       c;
    c = ~alu_cin_n;
    sum = '0;
    alu_y = '0;
    alu_cout_n = 1'b1;
    if (alu_m == MODE_LOGIC) begin
      case (alu_s)
        4'd6:    alu_y = alu_a ^ alu_b;
        4'd11:   alu_y = alu_a & alu_b;
        4'd14:   alu_y = alu_a | alu_b;
        default: alu_y = ~alu_a;
      endcase
    end else begin
      case (alu_s)
        4'd9:    sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, c};
        4'd6:    sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, c};
        default: sum = {1'b0, alu_a} + {4'd0, c};
      endcase
      alu_y = sum[3:0];
      alu_cout_n = ~sum[4];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] xsel(input logic [3:0] s,
                                        input logic [W-1:0] b);
    if (s == 4'd9) return b;
    if (s == 4'd6) return ~b;
    return '0;
  endfunction

  // Reference model: whole-word arithmetic, slice count only for timing
  int           mk = -1;
  logic [W-1:0] ma = '0, mb = '0;
  logic [3:0]   ms = '0;
  logic         mm = 1'b0, mcin = 1'b1;
  logic [W-1:0] pend_res = '0, exp_res = '0;
  logic         pend_cout = 1'b1, exp_cout = 1'b1;
  logic         exp_zero = 1'b0, exp_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [W:0] full;
    if (!rst_n) begin
      mk = -1;
      exp_res = '0;
      exp_cout = 1'b1;
      exp_zero = 1'b0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (mk >= 0) begin
        mk++;
        if (mk == N) begin
          mk = -1;
          exp_done = 1'b1;
          exp_res = pend_res;
          exp_cout = pend_cout;
          exp_zero = (pend_res == '0);
        end
      end else if (start) begin
        ma = opa; mb = opb; ms = op_s; mm = op_m; mcin = cin_n;
        if (op_m == MODE_LOGIC) begin
          case (op_s)
            4'd6:    pend_res = opa ^ opb;
            4'd11:   pend_res = opa & opb;
            4'd14:   pend_res = opa | opb;
            default: pend_res = ~opa;
          endcase
          pend_cout = 1'b1;
        end else begin
          full = {1'b0, opa} + {1'b0, xsel(op_s, opb)} + (W+1)'(!cin_n);
          pend_res = full[W-1:0];
          pend_cout = ~full[W];
        end
        mk = 0;
      end
    end
  end

  function automatic logic exp_cin(input int k);
    logic [31:0] mask, sum;
    if (mm == MODE_LOGIC) return (k == 0) ? mcin : 1'b1;
    mask = (32'd1 << (4 * k)) - 32'd1;
    sum = (32'(ma) & mask) + (32'(xsel(ms, mb)) & mask) + 32'(!mcin);
    return ~sum[4*k];
  endfunction

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(mk >= 0));
    chk("done", 32'(done), 32'(exp_done));
    chk("result", 32'(result), 32'(exp_res));
    chk("cout_n", 32'(cout_n), 32'(exp_cout));
`ifdef SEQ_ZFLAG_EN
    chk("zero", 32'(zero), 32'(exp_zero));
`endif
    if (mk >= 0) begin
      chk("alu_a", 32'(alu_a), 32'((ma >> (4 * mk)) & 16'hF));
      chk("alu_b", 32'(alu_b), 32'((mb >> (4 * mk)) & 16'hF));
      chk("alu_s", 32'(alu_s), 32'(ms));
      chk("alu_m", 32'(alu_m), 32'(mm));
      chk("alu_cin_n", 32'(alu_cin_n), 32'(exp_cin(mk)));
    end else begin
      chk("alu_idle", {alu_a, alu_b, alu_s, 1'b0, alu_m, alu_cin_n},
          32'h0000_0001);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m, input logic ci,
                        output int lat, output int bcnt);
    opa = a; opb = b; op_s = s; op_m = m; cin_n = ci;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      bcnt += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, bc, dn;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_cout_n", 32'(cout_n), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(posedge clk); #1;

    run_op(16'h00FF, 16'h0001, 4'd9, MODE_ARITH, 1'b1, lat, bc);
    chk("add_res", 32'(result), 32'h0100);
    chk("add_cout", 32'(cout_n), 32'h1);
    chk("add_lat", 32'(lat), 32'd5);
    @(posedge clk); #1;

    run_op(16'hFFFF, 16'h0001, 4'd9, MODE_ARITH, 1'b1, lat, bc);
    chk("carry_res", 32'(result), 32'h0000);
    chk("carry_cout", 32'(cout_n), 32'h0);
`ifdef SEQ_ZFLAG_EN
    chk("carry_zero", 32'(zero), 32'h1);
`endif
    @(posedge clk); #1;

    run_op(16'hA5A5, 16'hFFFF, 4'd6, MODE_LOGIC, 1'b1, lat, bc);
    chk("xor_res", 32'(result), 32'h5A5A);
    chk("xor_busy", 32'(bc), 32'd4);
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0234, 4'd6, MODE_ARITH, 1'b0, lat, bc);
    chk("sub_res", 32'(result), 32'h1000);
    chk("sub_cout", 32'(cout_n), 32'h0);
    @(posedge clk); #1;

    // Second start during RUN must be ignored
    opa = 16'h00FF; opb = 16'h0001; op_s = 4'd9; op_m = MODE_ARITH;
    cin_n = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    opa = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      dn += int'(done);
      @(posedge clk); #1;
    end
    chk("ign_dones", 32'(dn), 32'd1);
    chk("ign_res", 32'(result), 32'h0100);

    // Reset in RUN cycle 2 aborts without a done pulse
    opa = 16'hFFFF; opb = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_res", 32'(result), 32'h0);
    chk("mid_rst_cout", 32'(cout_n), 32'h1);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      dn += int'(done);
      @(posedge clk); #1;
    end
    chk("mid_rst_dones", 32'(dn), 32'd0);
    run_op(16'h00FF, 16'h0001, 4'd9, MODE_ARITH, 1'b1, lat, bc);
    chk("post_rst_res", 32'(result), 32'h0100);
    chk("post_rst_lat", 32'(lat), 32'd5);
    @(posedge clk); #1;

    // Start held through DONE chains straight into the next RUN
    opa = 16'h0F00; opb = 16'h00F0; op_s = 4'd14; op_m = MODE_LOGIC;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    chk("b2b_done1", 32'(done), 32'h1);
    chk("b2b_res1", 32'(result), 32'h0FF0);
    opa = 16'h1234; opb = 16'h1111; op_s = 4'd9; op_m = MODE_ARITH;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'h1);
    chk("b2b_hold", 32'(result), 32'h0FF0);
    for (int i = 0; i < 10; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    chk("b2b_res2", 32'(result), 32'h2345);
    chk("b2b_cout2", 32'(cout_n), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_alu_seq.md
ACC_ALU_SEQ -- requirements
Module: acc_alu_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning number of 4-bit slices per operation (legal 2..8).
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk (in, 1, rising-edge clock), then rst_n (in, 1, async active-low reset).
REQ-003 SHALL have start (in, 1): request a new operation.
REQ-004 SHALL have op_s (in, 4) and op_m (in, 1): ALU function select and mode, with m=1 logical and m=0 arithmetic.
REQ-005 SHALL have cin_n (in, 1): active-low initial carry into slice 0.
REQ-006 SHALL have opa and opb (in, 4*NIBBLES each): operands.
REQ-007 SHALL have busy (out, 1), done (out, 1), result (out, 4*NIBBLES) and cout_n (out, 1, active-low final carry).
REQ-008 SHALL have alu_a, alu_b and alu_s (out, 4 each), plus alu_m and alu_cin_n (out, 1 each): drive to the external 4-bit ALU.
REQ-009 SHALL have alu_y (in, 4) and alu_cout_n (in, 1): combinational ALU return.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 SHALL, on start=1 in IDLE or DONE, latch opa, opb, op_s, op_m and cin_n, clear the slice counter, and enter RUN.
REQ-012 SHALL, in RUN, drive slice k (bits 4k+3:4k, LSB first) of the latched operands on alu_a/alu_b, and latched op_s/op_m on alu_s/alu_m.
REQ-013 SHALL drive alu_cin_n with the latched cin_n for k=0, and with the alu_cout_n registered from slice k-1 for k>0.
REQ-014 SHALL, each RUN cycle, register alu_y into result slice k and alu_cout_n into the carry register, then increment k.
REQ-015 SHALL go RUN->DONE after slice NIBBLES-1; done=1 only in DONE, so done pulses NIBBLES+1 cycles after the start edge.
REQ-016 SHALL have DONE last one cycle and return to IDLE unless start=1 (REQ-011).
REQ-017 SHALL assert busy in RUN only.
REQ-018 SHALL ignore start during RUN, with no effect on latched operands.
REQ-019 SHALL hold result and cout_n stable from DONE until the next accepted start.
REQ-020 SHALL leave the result of the previous operation visible on result while the next operation runs; result is only guaranteed valid with done=1.
REQ-021 SHALL compute carry in logic mode (m=1) identically but treat it as don't-care; cout_n reports the last registered value.
REQ-022 SHALL drive alu_* outputs to 0 (alu_cin_n=1) outside RUN.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-RUN, force IDLE and zero the slice counter, busy, done and result, with cout_n=1.
REQ-024 SHALL not produce a done pulse for an operation aborted by reset.

Configuration
REQ-025 SHALL, with SEQ_ZFLAG_EN defined, add an output zero (out, 1), registered alongside done, equal to 1 when the full result is all zeros, reset 0, held like result.
REQ-026 SHALL, without SEQ_ZFLAG_EN, have no zero port and no related logic.

Structure
REQ-027 SHALL place the FSM state enum and ALU mode constants (MODE_LOGIC=1, MODE_ARITH=0) in the shared package acc_pkg.
REQ-028 SHALL contain no sub-module; the external ALU is instantiated beside it by the parent, not inside it.

Verification (NIBBLES=4)
REQ-029 SHALL check add: m=0, s=9, cin_n=1, A=0x00FF, B=0x0001 -> result=0x0100, cout_n=1, done on cycle 5 after start.
REQ-030 SHALL check carry out: m=0, s=9, cin_n=1, A=0xFFFF, B=0x0001 -> result=0x0000, cout_n=0, zero=1 if SEQ_ZFLAG_EN.
REQ-031 SHALL check logic: m=1, s=6 (XOR), A=0xA5A5, B=0xFFFF -> result=0x5A5A, busy high exactly 4 cycles.
REQ-032 SHALL check start ignored: second start with A=0x1111 during RUN of the REQ-029 op -> result=0x0100, single done pulse.
REQ-033 SHALL check mid-op reset: rst_n=0 in RUN cycle 2 -> IDLE, result=0, done never asserted; a following start completes normally.
REQ-034 SHALL check back-to-back: start held high in DONE -> new RUN begins the next cycle, with no IDLE cycle.
